ws2812b_chain_driver: RTL and testbench

//  Parametrised next-generation WS2812B chain driver: NB_LEDS pixel frame, double-buffered (shadow/display)
//  so the host may load pixels while a frame is on the wire. Adds global brightness scaling, selectable

---
 rtl/ws2812b_chain_driver.sv | 270 +++++++++++++++++++++++++++
 tb/tb_ws2812b_chain_driver.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812b_chain_driver.sv
// ---------------------------------------------------------------------------
// ws2812b_chain_driver
//   Double-buffered WS2812B chain driver. The host writes pixels into a shadow
//   buffer at any time. A falling edge on latch_n copies the shadow buffer into
//   the display buffer and transmits it on the single-wire data line. Each
//   pixel is brightness-scaled as it is loaded into the shift register, then
//   sent MSB first in the selected colour order. After the last LED the line
//   is held low for the latch gap, and frame_done pulses for one cycle.
//   A latch request made while a frame is in flight is queued (one deep) and
//   starts the next frame straight after the gap.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high reset
//   address      LED index written when load=1 (indices >= NB_LEDS ignored)
//   red/green/blue  pixel components written into the shadow buffer
//   load         write {red,green,blue} into shadow[address] this cycle
//   latch_n      falling edge requests transmission of the shadow frame
//   brightness   global scale factor, applied as each pixel is serialised
//   data_ws2812b serial line to the first LED
//   busy         high from frame start through the end of the latch gap
//   frame_done   one-cycle pulse when the latch gap completes
// ---------------------------------------------------------------------------
module ws2812b_chain_driver #(
    parameter int NB_LEDS     = 12,
    parameter int ADDR_W      = 8,
    parameter int T0H_CYC     = 20,
    parameter int T1H_CYC     = 40,
    parameter int TBIT_CYC    = 63,
    parameter int TRST_CYC    = 2500,
    parameter int COLOR_ORDER = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic [7:0]        red,
    input  logic [7:0]        green,
    input  logic [7:0]        blue,
    input  logic              load,
    input  logic              latch_n,
    input  logic [7:0]        brightness,
    output logic              data_ws2812b,
    output logic              busy,
    output logic              frame_done
);

    localparam int IDX_W   = (NB_LEDS > 1) ? $clog2(NB_LEDS) : 1;
    localparam int CNT_MAX = (TRST_CYC > TBIT_CYC) ? TRST_CYC : TBIT_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    // Terminal counts: a state lasting N cycles exits when the counter is N-1.
    localparam logic [CNT_W-1:0] HI0_LAST = CNT_W'(T0H_CYC - 1);
    localparam logic [CNT_W-1:0] HI1_LAST = CNT_W'(T1H_CYC - 1);
    localparam logic [CNT_W-1:0] LO0_LAST = CNT_W'(TBIT_CYC - T0H_CYC - 1);
    localparam logic [CNT_W-1:0] LO1_LAST = CNT_W'(TBIT_CYC - T1H_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(TRST_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NB_LEDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COPY,
        S_PIX,
        S_BIT_HI,
        S_BIT_LO,
        S_GAP
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [4:0]         bit_q, bit_d;
    logic [23:0]        shreg_q, shreg_d;
    logic               pending_q, pending_d;
    logic               latch_n_q;
    logic               data_q, data_d;
    logic               busy_q, busy_d;
    logic               frame_done_q, frame_done_d;

    logic               latch_req;
    logic [NB_LEDS-1:0][23:0] display_all;

    assign latch_req = latch_n_q & ~latch_n;

    // -----------------------------------------------------------------------
    // Pixel buffers: one shadow/display register pair per LED. The display
    // copy happens in COPY, so a host load in the latch-edge cycle has already
    // reached the shadow register and is included in the frame.
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NB_LEDS; gi++) begin : g_pix
            logic [23:0] shadow_q, shadow_d;
            logic [23:0] display_q, display_d;

            always_comb begin
                shadow_d = shadow_q;
                if (load && (address == ADDR_W'(gi))) begin
                    shadow_d = {red, green, blue};
                end
                display_d = display_q;
                if (state_q == S_COPY) begin
                    display_d = shadow_q;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    shadow_q  <= '0;
                    display_q <= '0;
                end else begin
                    shadow_q  <= shadow_d;
                    display_q <= display_d;
                end
            end

            assign display_all[gi] = display_q;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Brightness scaling and colour ordering of the pixel at idx.
    // c' = (c * (brightness + 1)) >> 8, so 255 is unity and 0 is black.
    // -----------------------------------------------------------------------
    logic [23:0] pix_raw;
    logic [15:0] gain;
    logic [15:0] r_prod, g_prod, b_prod;
    logic [23:0] pix_word;

    always_comb begin
        pix_raw = display_all[idx_q];
        gain    = {8'd0, brightness} + 16'd1;
        r_prod  = {8'd0, pix_raw[23:16]} * gain;
        g_prod  = {8'd0, pix_raw[15:8]}  * gain;
        b_prod  = {8'd0, pix_raw[7:0]}   * gain;
        if (COLOR_ORDER == 0) begin
            pix_word = {g_prod[15:8], r_prod[15:8], b_prod[15:8]};
        end else begin
            pix_word = {r_prod[15:8], g_prod[15:8], b_prod[15:8]};
        end
    end

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            bit_q        <= '0;
            shreg_q      <= '0;
            pending_q    <= 1'b0;
            latch_n_q    <= 1'b1;
            data_q       <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            bit_q        <= bit_d;
            shreg_q      <= shreg_d;
            pending_q    <= pending_d;
            latch_n_q    <= latch_n;
            data_q       <= data_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    logic             last_pix;
    logic [CNT_W-1:0] hi_last;
    logic [CNT_W-1:0] lo_last;

    always_comb begin
        last_pix = (idx_q == IDX_LAST);
        hi_last  = shreg_q[23] ? HI1_LAST : HI0_LAST;
        lo_last  = shreg_q[23] ? LO1_LAST : LO0_LAST;

        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        idx_d     = idx_q;
        bit_d     = bit_q;
        shreg_d   = shreg_q;
        pending_d = pending_q;

        // Requests while a frame is in flight collapse into one pending flag.
        if (latch_req && (state_q != S_IDLE)) begin
            pending_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (latch_req) begin
                    state_d = S_COPY;
                end
            end
            S_COPY: begin
                cnt_d   = '0;
                idx_d   = '0;
                state_d = S_PIX;
            end
            S_PIX: begin
                cnt_d   = '0;
                shreg_d = pix_word;
                bit_d   = 5'd23;
                state_d = S_BIT_HI;
            end
            S_BIT_HI: begin
                if (cnt_q == hi_last) begin
                    cnt_d   = '0;
                    state_d = S_BIT_LO;
                end
            end
            S_BIT_LO: begin
                if ((bit_q == 5'd0) && !last_pix) begin
                    // Leave one cycle early: the PIX cycle is the final low
                    // cycle of this bit, keeping the bit period exact.
                    if (cnt_q == lo_last - CNT_W'(1)) begin
                        cnt_d   = '0;
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = S_PIX;
                    end
                end else if (cnt_q == lo_last) begin
                    cnt_d = '0;
                    if (bit_q == 5'd0) begin
                        state_d = S_GAP;
                    end else begin
                        bit_d   = bit_q - 5'd1;
                        shreg_d = {shreg_q[22:0], 1'b0};
                        state_d = S_BIT_HI;
                    end
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    if (pending_q || latch_req) begin
                        pending_d = 1'b0;
                        state_d   = S_COPY;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Output logic (registered so the line is glitch-free)
    // -----------------------------------------------------------------------
    always_comb begin
        data_d       = (state_d == S_BIT_HI);
        busy_d       = (state_d != S_IDLE);
        frame_done_d = (state_q == S_GAP) && (state_d != S_GAP);
    end

    assign data_ws2812b = data_q;
    assign busy         = busy_q;
    assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_ws2812b_chain_driver.sv
// ---------------------------------------------------------------------------
// tb_ws2812b_chain_driver
//   Drives two driver instances (colour order 0 and 1) with identical host
//   stimulus and decodes their serial lines back into bit frames, measuring
//   high widths, bit periods, latch gap, busy and frame_done. Expected frames
//   come from a pixel-array model of the shadow buffer, scaled with plain
//   integer arithmetic.
// ---------------------------------------------------------------------------
module tb_ws2812b_chain_driver;

    localparam int NB    = 2;
    localparam int T0H   = 20;
    localparam int T1H   = 40;
    localparam int TBIT  = 63;
    localparam int TRST  = 2500;
    localparam int NBITS = NB * 24;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] address;
    logic [7:0] red, green, blue;
    logic       load;
    logic       latch_n;
    logic [7:0] brightness;
    logic       d0, b0, f0, d1, b1, f1;

    always #10 clk = ~clk;

    ws2812b_chain_driver #(
        .NB_LEDS(NB), .ADDR_W(8), .T0H_CYC(T0H), .T1H_CYC(T1H),
        .TBIT_CYC(TBIT), .TRST_CYC(TRST), .COLOR_ORDER(0)
    ) u_dut0 (
        .clk(clk), .reset(reset), .address(address), .red(red), .green(green),
        .blue(blue), .load(load), .latch_n(latch_n), .brightness(brightness),
        .data_ws2812b(d0), .busy(b0), .frame_done(f0)
    );

    ws2812b_chain_driver #(
        .NB_LEDS(NB), .ADDR_W(8), .T0H_CYC(T0H), .T1H_CYC(T1H),
        .TBIT_CYC(TBIT), .TRST_CYC(TRST), .COLOR_ORDER(1)
    ) u_dut1 (
        .clk(clk), .reset(reset), .address(address), .red(red), .green(green),
        .blue(blue), .load(load), .latch_n(latch_n), .brightness(brightness),
        .data_ws2812b(d1), .busy(b1), .frame_done(f1)
    );

    int errors = 0;
    int checks = 0;

    // Shadow-buffer model
    int m_r[NB];
    int m_g[NB];
    int m_b[NB];

    function automatic int scale(input int c, input int br);
        return (c * (br + 1)) / 256;
    endfunction

    function automatic logic [NBITS-1:0] expected_frame(input int order, input int br);
        logic [NBITS-1:0] w;
        logic [7:0] r, g, b;
        w = '0;
        for (int i = 0; i < NB; i++) begin
            r = 8'(scale(m_r[i], br));
            g = 8'(scale(m_g[i], br));
            b = 8'(scale(m_b[i], br));
            if (order == 0) w[NBITS-1-24*i -: 24] = {g, r, b};
            else            w[NBITS-1-24*i -: 24] = {r, g, b};
        end
        return w;
    endfunction

    function automatic logic line_of(input int sel);
        return (sel != 0) ? d1 : d0;
    endfunction
    function automatic logic busy_of(input int sel);
        return (sel != 0) ? b1 : b0;
    endfunction
    function automatic logic fd_of(input int sel);
        return (sel != 0) ? f1 : f0;
    endfunction

    task automatic do_load(input int a, input int r, input int g, input int b);
        @(negedge clk);
        address = 8'(a); red = 8'(r); green = 8'(g); blue = 8'(b); load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        if (a < NB) begin
            m_r[a] = r; m_g[a] = g; m_b[a] = b;
        end
    endtask

    task automatic latch_pulse();
        @(negedge clk);
        latch_n = 1'b0;
        @(negedge clk);
        latch_n = 1'b1;
    endtask

    // Decode one frame from a serial line. Starts sampling on the next
    // falling clock edge and returns on the falling edge after frame_done.
    task automatic capture(input int sel, output logic [NBITS-1:0] bits,
                           output int tim_err, output int timeout,
                           output logic busy_done, output logic fd_after,
                           output int busy_drop);
        int h, l, n;
        logic [NBITS-1:0] acc;
        acc = '0; tim_err = 0; timeout = 0; busy_drop = 0;
        busy_done = 1'b0; fd_after = 1'b0;
        n = 0;
        @(negedge clk);
        while (line_of(sel) == 1'b0 && n < 300) begin
            n++;
            @(negedge clk);
        end
        if (n >= 300) begin
            timeout = 1;
            bits = acc;
            return;
        end
        for (int b = 0; b < NBITS; b++) begin
            h = 0;
            while (line_of(sel) == 1'b1 && h < 100) begin
                h++;
                if (!busy_of(sel)) busy_drop++;
                @(negedge clk);
            end
            if (h == T1H) acc = {acc[NBITS-2:0], 1'b1};
            else begin
                acc = {acc[NBITS-2:0], 1'b0};
                if (h != T0H) tim_err++;
            end
            l = 0;
            if (b < NBITS - 1) begin
                while (line_of(sel) == 1'b0 && l < 100) begin
                    l++;
                    if (!busy_of(sel)) busy_drop++;
                    @(negedge clk);
                end
                if (h + l != TBIT) tim_err++;
            end else begin
                while (fd_of(sel) == 1'b0 && l < TRST + 200) begin
                    l++;
                    if (line_of(sel)) tim_err++;
                    if (!busy_of(sel)) busy_drop++;
                    @(negedge clk);
                end
                if (l != TBIT - h + TRST) tim_err++;
                busy_done = busy_of(sel);
                @(negedge clk);
                fd_after = fd_of(sel);
            end
        end
        bits = acc;
        $display("frame line%0d bits=%h timing_errs=%0d busy_at_done=%0b", sel, bits, tim_err, busy_done);
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b1; load = 1'b0; latch_n = 1'b1; address = '0;
        red = '0; green = '0; blue = '0; brightness = 8'hFF;
        for (int i = 0; i < NB; i++) begin m_r[i] = 0; m_g[i] = 0; m_b[i] = 0; end
        repeat (3) @(negedge clk);
        checks++; if ({d0, b0, f0} !== 3'b000) begin errors++; $display("FAIL reset_dut0: got %b required 000", {d0, b0, f0}); end
        checks++; if ({d1, b1, f1} !== 3'b000) begin errors++; $display("FAIL reset_dut1: got %b required 000", {d1, b1, f1}); end
        reset = 1'b0;
        repeat (20) @(negedge clk);
        checks++; if ({d0, b0} !== 2'b00) begin errors++; $display("FAIL idle_after_reset: got %b required 00", {d0, b0}); end
    endtask

    task automatic test_basic_frame();
        logic [NBITS-1:0] got; int te, to, bd; logic bdone, fda;
        brightness = 8'hFF;
        do_load(0, 8'h33, 8'h44, 8'h55);
        do_load(1, 8'h66, 8'h77, 8'h88);
        latch_pulse();
        capture(0, got, te, to, bdone, fda, bd);
        checks++; if (to !== 0) begin errors++; $display("FAIL basic_timeout: no frame start"); end
        checks++; if (got !== 48'h443355776688) begin errors++; $display("FAIL basic_bits: got %h required 443355776688", got); end
        checks++; if (got !== expected_frame(0, 255)) begin errors++; $display("FAIL basic_model: got %h required %h", got, expected_frame(0, 255)); end
        checks++; if (te !== 0) begin errors++; $display("FAIL basic_timing: got %0d bad bit/gap widths required 0", te); end
        checks++; if (bd !== 0) begin errors++; $display("FAIL basic_busy: busy low %0d cycles in frame required 0", bd); end
        checks++; if (bdone !== 1'b0) begin errors++; $display("FAIL basic_busy_done: got %b required 0", bdone); end
        checks++; if (fda !== 1'b0) begin errors++; $display("FAIL basic_done_width: frame_done got %b one cycle later required 0", fda); end
    endtask

    task automatic test_brightness();
        logic [NBITS-1:0] got; int te, to, bd; logic bdone, fda;
        brightness = 8'h7F;
        do_load(0, 8'h80, 8'h80, 8'h80);
        latch_pulse();
        capture(0, got, te, to, bdone, fda, bd);
        checks++; if (got[NBITS-1 -: 24] !== 24'h404040) begin errors++; $display("FAIL bright7f_led0: got %h required 404040", got[NBITS-1 -: 24]); end
        checks++; if (got !== expected_frame(0, 8'h7F)) begin errors++; $display("FAIL bright7f_model: got %h required %h", got, expected_frame(0, 8'h7F)); end
        checks++; if (te !== 0 || to !== 0) begin errors++; $display("FAIL bright7f_timing: got errs=%0d timeout=%0d required 0/0", te, to); end
        brightness = 8'h00;
        latch_pulse();
        capture(0, got, te, to, bdone, fda, bd);
        checks++; if (got !== 48'h0 || to !== 0) begin errors++; $display("FAIL bright00_bits: got %h timeout=%0d required 0", got, to); end
        brightness = 8'hFF;
    endtask

    task automatic test_back_to_back();
        logic [NBITS-1:0] got1, got2, exp1; int te1, to1, bd1, te2, to2, bd2;
        logic bdone1, fda1, bdone2, fda2;
        exp1 = expected_frame(0, 255);
        latch_pulse();
        fork
            capture(0, got1, te1, to1, bdone1, fda1, bd1);
            begin
                repeat (500) @(negedge clk);
                do_load(0, 8'hFF, 8'h00, 8'h00);
                latch_pulse();
            end
        join
        checks++; if (got1 !== exp1) begin errors++; $display("FAIL b2b_frame1: got %h required %h", got1, exp1); end
        checks++; if (bdone1 !== 1'b1) begin errors++; $display("FAIL b2b_busy_between: got %b required 1", bdone1); end
        capture(0, got2, te2, to2, bdone2, fda2, bd2);
        checks++; if (to2 !== 0) begin errors++; $display("FAIL b2b_frame2_timeout: second frame did not follow"); end
        checks++; if (got2[NBITS-1 -: 16] !== 16'h00FF) begin errors++; $display("FAIL b2b_frame2_gr: got %h required 00ff", got2[NBITS-1 -: 16]); end
        checks++; if (got2 !== expected_frame(0, 255)) begin errors++; $display("FAIL b2b_frame2_model: got %h required %h", got2, expected_frame(0, 255)); end
        checks++; if (bdone2 !== 1'b0 || bd2 !== 0 || te2 !== 0) begin errors++; $display("FAIL b2b_end: busy_done=%b drops=%0d timing=%0d required 0/0/0", bdone2, bd2, te2); end
    endtask

    task automatic test_ignore_and_hold();
        logic [NBITS-1:0] got; int te, to, bd, highs; logic bdone, fda;
        do_load(5, 8'h12, 8'h34, 8'h56);
        @(negedge clk);
        latch_n = 1'b0;
        fork
            capture(0, got, te, to, bdone, fda, bd);
            begin
                repeat (100) @(negedge clk);
                latch_n = 1'b1;
            end
        join
        checks++; if (got !== expected_frame(0, 255)) begin errors++; $display("FAIL ignore_addr5: got %h required %h", got, expected_frame(0, 255)); end
        checks++; if (bdone !== 1'b0) begin errors++; $display("FAIL hold_single: busy at done got %b required 0", bdone); end
        highs = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (d0) highs++;
        end
        checks++; if (highs !== 0 || b0 !== 1'b0) begin errors++; $display("FAIL hold_no_retrigger: got highs=%0d busy=%b required 0/0", highs, b0); end
    endtask

    task automatic test_reset_mid_frame();
        logic [NBITS-1:0] got; int te, to, bd; logic bdone, fda;
        latch_pulse();
        repeat (2 + 24 * TBIT + 25) @(negedge clk);
        checks++; if (b0 !== 1'b1) begin errors++; $display("FAIL midreset_pre_busy: got %b required 1", b0); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if ({d0, b0, f0, d1, b1} !== 5'b00000) begin errors++; $display("FAIL midreset_outputs: got %b required 00000", {d0, b0, f0, d1, b1}); end
        reset = 1'b0;
        for (int i = 0; i < NB; i++) begin m_r[i] = 0; m_g[i] = 0; m_b[i] = 0; end
        repeat (5) @(negedge clk);
        latch_pulse();
        capture(0, got, te, to, bdone, fda, bd);
        checks++; if (got !== 48'h0 || to !== 0) begin errors++; $display("FAIL midreset_zero_frame: got %h timeout=%0d required 0", got, to); end
    endtask

    task automatic test_color_order();
        logic [NBITS-1:0] got0, got1; int te0, to0, bd0, te1, to1, bd1;
        logic bdn0, fd0, bdn1, fd1;
        brightness = 8'hFF;
        @(negedge clk);
        address = 8'd0; red = 8'h33; green = 8'h44; blue = 8'h55;
        load = 1'b1; latch_n = 1'b0;
        @(negedge clk);
        load = 1'b0; latch_n = 1'b1;
        m_r[0] = 8'h33; m_g[0] = 8'h44; m_b[0] = 8'h55;
        fork
            capture(0, got0, te0, to0, bdn0, fd0, bd0);
            capture(1, got1, te1, to1, bdn1, fd1, bd1);
        join
        checks++; if (got1[NBITS-1 -: 24] !== 24'h334455) begin errors++; $display("FAIL order1_led0: got %h required 334455", got1[NBITS-1 -: 24]); end
        checks++; if (got0[NBITS-1 -: 24] !== 24'h443355) begin errors++; $display("FAIL order0_same_cycle_load: got %h required 443355", got0[NBITS-1 -: 24]); end
        checks++; if (got1 !== expected_frame(1, 255) || te1 !== 0) begin errors++; $display("FAIL order1_model: got %h timing=%0d required %h", got1, te1, expected_frame(1, 255)); end
    endtask

    task automatic test_random();
        logic [NBITS-1:0] got0, got1; int te0, to0, bd0, te1, to1, bd1;
        logic bdn0, fd0, bdn1, fd1;
        int br;
        for (int it = 0; it < 2; it++) begin
            br = $urandom_range(0, 255);
            brightness = 8'(br);
            for (int i = 0; i < NB; i++)
                do_load(i, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
            latch_pulse();
            fork
                capture(0, got0, te0, to0, bdn0, fd0, bd0);
                capture(1, got1, te1, to1, bdn1, fd1, bd1);
            join
            checks++; if (got0 !== expected_frame(0, br) || te0 !== 0) begin errors++; $display("FAIL random%0d_order0: got %h timing=%0d required %h", it, got0, te0, expected_frame(0, br)); end
            checks++; if (got1 !== expected_frame(1, br) || te1 !== 0) begin errors++; $display("FAIL random%0d_order1: got %h timing=%0d required %h", it, got1, te1, expected_frame(1, br)); end
        end
    endtask

    initial begin
        #(20 * 150000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_frame();
        test_brightness();
        test_back_to_back();
        test_ignore_and_hold();
        test_reset_mid_frame();
        test_color_order();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
